reg_sequencer: RTL and testbench

REG_SEQUENCER -- requirements
Module: reg_sequencer

---
 rtl/reg_seq_pkg.sv | 53 +++++
 rtl/seq_alu.sv | 58 +++++
 rtl/reg_sequencer.sv | 160 ++++++++++++++++
 tb/tb_reg_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register sequencer: opcode values, FSM state
// encoding, instruction field positions and small opcode classifiers.
// All vectors use ascending ranges, so index 0 is the most significant bit.
package reg_seq_pkg;

   localparam int INSTR_W = 16;
   localparam int OPC_W   = 4;
   localparam int FIELD_W = 4;
   localparam int IMM_W   = 8;

   // Field positions inside instr[0:15]; imm overlaps srcA/srcB.
   localparam int OPC_FIRST  = 0;
   localparam int OPC_LAST   = 3;
   localparam int DST_FIRST  = 4;
   localparam int DST_LAST   = 7;
   localparam int SRCA_FIRST = 8;
   localparam int SRCA_LAST  = 11;
   localparam int SRCB_FIRST = 12;
   localparam int SRCB_LAST  = 15;
   localparam int IMM_FIRST  = 8;
   localparam int IMM_LAST   = 15;

   // Opcode values; 10..15 are undefined and behave as NOP.
   localparam logic [0:OPC_W-1] OP_NOP = 4'd0;
   localparam logic [0:OPC_W-1] OP_ADD = 4'd1;
   localparam logic [0:OPC_W-1] OP_SUB = 4'd2;
   localparam logic [0:OPC_W-1] OP_AND = 4'd3;
   localparam logic [0:OPC_W-1] OP_OR  = 4'd4;
   localparam logic [0:OPC_W-1] OP_XOR = 4'd5;
   localparam logic [0:OPC_W-1] OP_MOV = 4'd6;
   localparam logic [0:OPC_W-1] OP_LDI = 4'd7;
   localparam logic [0:OPC_W-1] OP_SHL = 4'd8;
   localparam logic [0:OPC_W-1] OP_SHR = 4'd9;

   // Sequencer FSM: one instruction every four cycles.
   typedef enum logic [0:1] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   // Opcodes that produce a register write (ADD .. SHR).
   function automatic logic op_writes(input logic [0:OPC_W-1] op);
      return (op >= OP_ADD) && (op <= OP_SHR);
   endfunction

   // Opcodes outside the defined set.
   function automatic logic op_illegal(input logic [0:OPC_W-1] op);
      return op > OP_SHR;
   endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the register sequencer. Flags that an opcode does
// not define are passed through from carry_in so the caller can register
// carry_out unconditionally.
module seq_alu
   import reg_seq_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [0:OPC_W-1]  op,
   input  logic [0:DATA_W-1] a,
   input  logic [0:DATA_W-1] b,
   input  logic [0:DATA_W-1] imm,
   input  logic              carry_in,
   output logic [0:DATA_W-1] result,
   output logic              carry_out
);

   // One extra leading bit holds the ADD carry-out / SUB borrow.
   logic [0:DATA_W] sum_ext;
   logic [0:DATA_W] diff_ext;

   assign sum_ext  = {1'b0, a} + {1'b0, b};
   assign diff_ext = {1'b0, a} - {1'b0, b};

   // Opcode decode; result wraps modulo 2^DATA_W, carry kept unless defined.
   always_comb begin
      result    = '0;
      carry_out = carry_in;
      case (op)
         OP_ADD: begin
            result    = sum_ext[1:DATA_W];
            carry_out = sum_ext[0];
         end
         OP_SUB: begin
            result    = diff_ext[1:DATA_W];
            carry_out = diff_ext[0];
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_MOV: result = a;
         OP_LDI: result = imm;
         OP_SHL: begin
            result    = {a[1:DATA_W-1], 1'b0};
            carry_out = a[0];
         end
         OP_SHR: begin
            result    = {1'b0, a[0:DATA_W-2]};
            carry_out = a[DATA_W-1];
         end
         default: begin
            result    = '0;
            carry_out = carry_in;
         end
      endcase
   end

endmodule

// File: rtl/reg_sequencer.sv
// Four-phase instruction sequencer driving an external register file:
// accept in IDLE, read operands in READ, compute in EXEC, write back in WB.
module reg_sequencer
   import reg_seq_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [0:15]       instr,
   output logic              instr_ready,
   input  logic [0:DATA_W-1] A,
   input  logic [0:DATA_W-1] B,
   output logic [0:SEL_W-1]  A_sel,
   output logic [0:SEL_W-1]  B_sel,
   output logic [0:SEL_W-1]  replaceSel,
   output logic [0:DATA_W-1] replaceData,
   output logic              wr_en,
   output logic              done,
   output logic              carry,
   output logic              zero,
   output logic              illegal
);

   state_t              state_reg;
   state_t              state_next;
   logic [0:INSTR_W-1]  instr_reg;
   logic [0:DATA_W-1]   a_reg;
   logic [0:DATA_W-1]   b_reg;
   logic [0:DATA_W-1]   result_reg;
   logic                carry_reg;
   logic                zero_reg;
   logic [0:SEL_W-1]    a_sel_reg;
   logic [0:SEL_W-1]    b_sel_reg;

   logic [0:OPC_W-1]    op;
   logic [0:SEL_W-1]    dst;
   logic [0:SEL_W-1]    src_a;
   logic [0:SEL_W-1]    src_b;
   logic [0:DATA_W-1]   imm_ext;
   logic [0:DATA_W-1]   alu_result;
   logic                alu_carry;
   logic                zero_next;
   logic                accept;

   // Field extraction from the latched instruction.
   assign op      = instr_reg[OPC_FIRST:OPC_LAST];
   assign dst     = SEL_W'(instr_reg[DST_FIRST:DST_LAST]);
   assign src_a   = SEL_W'(instr_reg[SRCA_FIRST:SRCA_LAST]);
   assign src_b   = SEL_W'(instr_reg[SRCB_FIRST:SRCB_LAST]);
   assign imm_ext = DATA_W'(instr_reg[IMM_FIRST:IMM_LAST]);

   assign accept = instr_valid & instr_ready;

   // Write port mirrors the latched destination and result; wr_en qualifies it.
   assign replaceSel  = dst;
   assign replaceData = result_reg;
   assign carry       = carry_reg;
   assign zero        = zero_reg;

   seq_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op        (op),
      .a         (a_reg),
      .b         (b_reg),
      .imm       (imm_ext),
      .carry_in  (carry_reg),
      .result    (alu_result),
      .carry_out (alu_carry)
   );

   // Zero only follows instructions that actually write a register.
   assign zero_next = op_writes(op) ? (alu_result == '0) : zero_reg;

   // State register; reset abandons any in-flight instruction immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and per-state strobes/selects.
   always_comb begin
      state_next  = state_reg;
      instr_ready = 1'b0;
      wr_en       = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      A_sel       = a_sel_reg;
      B_sel       = b_sel_reg;
      case (state_reg)
         IDLE: begin
            instr_ready = ~rst;
            if (instr_valid && !rst) begin
               state_next = READ;
            end
         end
         READ: begin
            A_sel      = src_a;
            B_sel      = src_b;
            state_next = EXEC;
         end
         EXEC: begin
            A_sel      = src_a;
            B_sel      = src_b;
            state_next = WB;
         end
         WB: begin
            done       = 1'b1;
            wr_en      = op_writes(op);
            illegal    = op_illegal(op);
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: latch instruction, capture operands, then result and flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_reg  <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
         carry_reg  <= 1'b0;
         zero_reg   <= 1'b0;
         a_sel_reg  <= '0;
         b_sel_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  instr_reg <= instr;
               end
            end
            READ: begin
               a_reg     <= A;
               b_reg     <= B;
               a_sel_reg <= src_a;
               b_sel_reg <= src_b;
            end
            EXEC: begin
               result_reg <= alu_result;
               carry_reg  <= alu_carry;
               zero_reg   <= zero_next;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_sequencer.sv
// Self-checking bench for reg_sequencer: directed scenarios followed by
// randomized instructions, checked against an arithmetic reference model.
module tb_reg_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [0:15] instr = '0;
   logic        instr_ready;
   logic [0:7]  A, B;
   logic [0:3]  A_sel, B_sel, replaceSel;
   logic [0:7]  replaceData;
   logic        wr_en, done, carry, zero, illegal;

   // External register file with a bench-side preload port.
   logic [0:7]  rf [16];
   logic        pre_we = 1'b0;
   logic [0:3]  pre_sel = '0;
   logic [0:7]  pre_data = '0;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   // Reference model state.
   int mdl_regs [16];
   int mdl_c = 0;
   int mdl_z = 0;
   int last_accept = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (pre_we) rf[pre_sel] <= pre_data;
      else if (wr_en) rf[replaceSel] <= replaceData;
   end

   assign A = rf[A_sel];
   assign B = rf[B_sel];

   reg_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .A           (A),
      .B           (B),
      .A_sel       (A_sel),
      .B_sel       (B_sel),
      .replaceSel  (replaceSel),
      .replaceData (replaceData),
      .wr_en       (wr_en),
      .done        (done),
      .carry       (carry),
      .zero        (zero),
      .illegal     (illegal)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic preload(input int sel, input int val);
      pre_we = 1'b1;
      pre_sel = 4'(sel);
      pre_data = 8'(val);
      mdl_regs[sel] = val;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Issue one instruction from a negedge in IDLE and check every phase.
   task automatic exec_instr(input logic [15:0] h, input bit hold_valid);
      int waited = 0;
      int op, d, sa, sb, im, a, b, res, wr, ill;
      op = int'(h[15:12]); d = int'(h[11:8]);
      sa = int'(h[7:4]);   sb = int'(h[3:0]); im = int'(h[7:0]);
      instr = h;
      instr_valid = 1'b1;
      while (!instr_ready && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      check_val("ready_idle", int'(instr_ready), 1);
      last_accept = cyc;
      a = mdl_regs[sa];
      b = mdl_regs[sb];
      res = 0;
      wr = (op >= 1 && op <= 9) ? 1 : 0;
      ill = (op >= 10) ? 1 : 0;
      case (op)
         1: begin res = (a + b) % 256; mdl_c = (a + b > 255) ? 1 : 0; end
         2: begin res = (a - b + 256) % 256; mdl_c = (a < b) ? 1 : 0; end
         3: res = a & b;
         4: res = a | b;
         5: res = a ^ b;
         6: res = a;
         7: res = im;
         8: begin res = (a * 2) % 256; mdl_c = (a >= 128) ? 1 : 0; end
         9: begin res = a / 2; mdl_c = a % 2; end
         default: res = 0;
      endcase
      if (wr == 1) mdl_z = (res == 0) ? 1 : 0;

      @(negedge clk);  // READ
      if (!hold_valid) instr_valid = 1'b0;
      check_val("ready_read", int'(instr_ready), 0);
      check_val("asel_read", int'(A_sel), sa);
      check_val("bsel_read", int'(B_sel), sb);
      check_val("wr_read", int'({wr_en, done}), 0);

      @(negedge clk);  // EXEC
      check_val("ready_exec", int'(instr_ready), 0);
      check_val("asel_exec", int'(A_sel), sa);
      check_val("wr_exec", int'({wr_en, done}), 0);

      @(negedge clk);  // WB
      check_val("ready_wb", int'(instr_ready), 0);
      check_val("done_wb", int'(done), 1);
      check_val("wr_en_wb", int'(wr_en), wr);
      check_val("illegal_wb", int'(illegal), ill);
      if (wr == 1) begin
         check_val("rsel_wb", int'(replaceSel), d);
         check_val("rdata_wb", int'(replaceData), res);
         mdl_regs[d] = res;
      end
      check_val("carry_wb", int'(carry), mdl_c);
      check_val("zero_wb", int'(zero), mdl_z);

      @(negedge clk);  // back in IDLE
      check_val("done_idle", int'({done, wr_en, illegal}), 0);
      check_val("asel_hold", int'(A_sel), sa);
      check_val("rf_dst", int'(rf[d]), mdl_regs[d]);
      $display("instr %04h op=%0d dst=%0d a=%02h b=%02h res=%02h c=%0d z=%0d",
               h, op, d, a, b, res, mdl_c, mdl_z);
   endtask

   initial begin
      int acc1;
      logic [15:0] h;
      // Reset state.
      repeat (2) @(negedge clk);
      check_val("rst_ready", int'(instr_ready), 0);
      check_val("rst_flags", int'({wr_en, done, illegal, carry, zero}), 0);
      check_val("rst_sels", int'({A_sel, B_sel, replaceSel}), 0);
      check_val("rst_rdata", int'(replaceData), 0);
      rst = 1'b0;
      #1;
      check_val("ready_after_rst", int'(instr_ready), 1);
      @(negedge clk);
      for (int i = 0; i < 16; i++) preload(i, int'($urandom_range(0, 255)));
      preload(1, 8'hF0);
      preload(2, 8'h20);
      preload(5, 8'h3C);
      preload(6, 8'h3C);

      // LDI r3, 0xA5
      exec_instr(16'h73A5, 1'b0);
      // ADD r4, r1, r2 -> 0x10 with carry
      exec_instr(16'h1412, 1'b0);
      check_val("add_ovf_carry", int'(carry), 1);
      // SUB r5, r5, r6 -> 0, zero set, no borrow
      exec_instr(16'h2556, 1'b0);
      check_val("sub_eq_zero", int'({zero, carry}), 2);
      // Illegal opcode keeps flags.
      exec_instr(16'hC123, 1'b0);
      // Back-to-back with valid held high.
      exec_instr(16'h5712, 1'b1);
      acc1 = last_accept;
      exec_instr(16'h3834, 1'b0);
      check_val("b2b_spacing", last_accept - acc1, 4);

      // Reset during EXEC of an ADD r7, r1, r2.
      instr = 16'h1712;
      instr_valid = 1'b1;
      check_val("ready_pre_rst", int'(instr_ready), 1);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("async_rst_flags", int'({instr_ready, wr_en, done, illegal, carry, zero}), 0);
      check_val("async_rst_sels", int'({A_sel, B_sel, replaceSel}), 0);
      check_val("async_rst_rdata", int'(replaceData), 0);
      @(negedge clk);
      check_val("rst_hold_flags", int'({wr_en, done}), 0);
      rst = 1'b0;
      #1;
      check_val("ready_release", int'(instr_ready), 1);
      mdl_c = 0;
      mdl_z = 0;
      repeat (3) begin
         @(negedge clk);
         check_val("no_wb_after_rst", int'({wr_en, done}), 0);
      end
      check_val("rf_r7_untouched", int'(rf[7]), mdl_regs[7]);
      $display("reset in EXEC abandoned ADD r7");

      // Randomized instructions.
      for (int i = 0; i < 40; i++) begin
         h = 16'($urandom());
         exec_instr(h, 1'($urandom_range(0, 1)));
      end
      instr_valid = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "timeout");
   end

endmodule
